// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: tile geometry, instruction
// word layout, FSM states and the field->word packer.
package core_pkg;

    localparam int COL      = 8;
    localparam int ROW      = 8;
    localparam int LEN_KIJ  = 9;
    localparam int LEN_NIJ  = 36;
    localparam int LEN_ONIJ = 16;
    localparam int GAP      = 10;

    localparam int INST_W = 34;

    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_A_P      = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_A_X      = 9;
    localparam int B_MODE     = 8;
    localparam int B_A_X0     = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    localparam logic [10:0] XMEM_W_BASE = 11'h400;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_L0,
        S_LOAD,
        S_GAP,
        S_X_L0,
        S_IF_WR,
        S_EXEC,
        S_OF_RD,
        S_ACC_CLR,
        S_ACC_RD,
        S_ACC_WAIT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic        acc;
        logic        cen_p;
        logic        wen_p;
        logic [10:0] a_p;
        logic        cen_x;
        logic        wen_x;
        logic [10:0] a_x;
        logic        mode;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    localparam inst_t INST_IDLE = '{
        acc:      1'b0,
        cen_p:    1'b1,
        wen_p:    1'b1,
        a_p:      11'd0,
        cen_x:    1'b1,
        wen_x:    1'b1,
        a_x:      11'd0,
        mode:     1'b0,
        ofifo_rd: 1'b0,
        ififo_wr: 1'b0,
        ififo_rd: 1'b0,
        l0_rd:    1'b0,
        l0_wr:    1'b0,
        execute:  1'b0,
        load:     1'b0
    };

    // The core decodes xmem address bit 1 itself, so it has no slot here.
    function automatic logic [INST_W-1:0] pack_inst(input inst_t f);
        logic [INST_W-1:0] w;
        logic              unused_ax1;
        w               = '0;
        unused_ax1      = f.a_x[1];
        w[B_ACC]        = f.acc;
        w[B_CEN_P]      = f.cen_p;
        w[B_WEN_P]      = f.wen_p;
        w[B_A_P +: 11]  = f.a_p;
        w[B_CEN_X]      = f.cen_x;
        w[B_WEN_X]      = f.wen_x;
        w[B_A_X +: 9]   = f.a_x[10:2];
        w[B_MODE]       = f.mode;
        w[B_A_X0]       = f.a_x[0];
        w[B_OFIFO_RD]   = f.ofifo_rd;
        w[B_IFIFO_WR]   = f.ififo_wr;
        w[B_IFIFO_RD]   = f.ififo_rd;
        w[B_L0_RD]      = f.l0_rd;
        w[B_L0_WR]      = f.l0_wr;
        w[B_EXEC]       = f.execute;
        w[B_LOAD]       = f.load;
        return w;
    endfunction

    localparam logic [INST_W-1:0] INST_IDLE_W = pack_inst(INST_IDLE);

    function automatic logic [5:0] phase_last(input state_e s);
        logic [5:0] n;
        unique case (s)
            S_W_L0,
            S_LOAD:   n = 6'(COL - 1);
            S_GAP:    n = 6'(GAP - 1);
            S_X_L0,
            S_IF_WR:  n = 6'(LEN_NIJ - 1);
            S_EXEC:   n = 6'(LEN_NIJ + COL + ROW - 1);
            S_OF_RD:  n = 6'(LEN_ONIJ - 1);
            S_ACC_RD: n = 6'(LEN_KIJ);
            default:  n = 6'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/core_inst_pack.sv
// Combinational packer from instruction fields to the 34-bit core word.
module core_inst_pack
    import core_pkg::*;
(
    input  inst_t              fields_i,
    output logic [INST_W-1:0]  inst_o
);

    assign inst_o = pack_inst(fields_i);

endmodule

// File: rtl/core_seq_ctrl.sv
// Tile sequencer: walks every kernel position through the core datapath,
// then accumulates partial sums per output pixel from pmem.
module core_seq_ctrl
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode_in,
    output logic [33:0] inst,
    output logic        core_clr,
    output logic        out_valid,
    output logic [3:0]  out_idx,
    output logic        busy,
    output logic        done
);

    state_e      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  o_q, o_d;
    logic        mode_q, mode_d;

    logic [INST_W-1:0] inst_q, inst_d;
    logic        clr_q, clr_d;
    logic        ov_q, ov_d;
    logic [3:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    inst_t       f;
    logic        last;

    core_inst_pack u_pack (
        .fields_i (f),
        .inst_o   (inst_d)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        o_d     = o_q;
        mode_d  = mode_q;
        clr_d   = 1'b0;
        ov_d    = 1'b0;
        idx_d   = 4'd0;
        done_d  = 1'b0;
        busy_d  = (state_q != S_IDLE) && (state_q != S_DONE);
        last    = (t_q == phase_last(state_q));
        t_d     = last ? 6'd0 : t_q + 6'd1;
        f       = INST_IDLE;
        f.mode  = (state_q != S_IDLE) ? mode_q : 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_W_L0;
                    k_d     = 4'd0;
                    mode_d  = mode_in;
                end
            end
            S_W_L0: begin
                f.cen_x = 1'b0;
                f.l0_wr = 1'b1;
                f.a_x   = XMEM_W_BASE + 11'(int'(k_q) * COL) + 11'(t_q);
                if (last) state_d = S_LOAD;
            end
            S_LOAD: begin
                f.load  = 1'b1;
                f.l0_rd = 1'b1;
                if (last) state_d = S_GAP;
            end
            S_GAP: begin
                if (last) state_d = S_X_L0;
            end
            S_X_L0: begin
                f.cen_x = 1'b0;
                f.l0_wr = 1'b1;
                f.a_x   = 11'(t_q);
                if (last) state_d = S_IF_WR;
            end
            S_IF_WR: begin
                f.l0_rd    = 1'b1;
                f.ififo_wr = 1'b1;
                if (last) state_d = S_EXEC;
            end
            S_EXEC: begin
                f.execute  = 1'b1;
                f.ififo_rd = 1'b1;
                if (last) state_d = S_OF_RD;
            end
            S_OF_RD: begin
                f.ofifo_rd = 1'b1;
                if (last) begin
                    if (k_q == 4'(LEN_KIJ - 1)) begin
                        state_d = S_ACC_CLR;
                        o_d     = 4'd0;
                    end else begin
                        state_d = S_W_L0;
                        k_d     = k_q + 4'd1;
                    end
                end
            end
            S_ACC_CLR: begin
                clr_d   = 1'b1;
                state_d = S_ACC_RD;
            end
            S_ACC_RD: begin
                // One extra cycle past the last read lets acc fold in its data.
                if (t_q < 6'(LEN_KIJ)) begin
                    f.cen_p = 1'b0;
                    f.a_p   = 11'(int'(t_q) * LEN_ONIJ + int'(o_q));
                end
                f.acc = (t_q != 6'd0);
                if (last) state_d = S_ACC_WAIT;
            end
            S_ACC_WAIT: begin
                ov_d  = 1'b1;
                idx_d = o_q;
                if (o_q == 4'(LEN_ONIJ - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACC_CLR;
                    o_d     = o_q + 4'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            t_q     <= 6'd0;
            k_q     <= 4'd0;
            o_q     <= 4'd0;
            mode_q  <= 1'b0;
            inst_q  <= INST_IDLE_W;
            clr_q   <= 1'b0;
            ov_q    <= 1'b0;
            idx_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            o_q     <= o_d;
            mode_q  <= mode_d;
            inst_q  <= inst_d;
            clr_q   <= clr_d;
            ov_q    <= ov_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign inst      = inst_q;
    assign core_clr  = clr_q;
    assign out_valid = ov_q;
    assign out_idx   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: a per-cycle expected schedule is built from the
// tile phase list and compared against the registered outputs.
module tb_core_seq_ctrl;

    localparam int COL      = 8;
    localparam int ROW      = 8;
    localparam int LEN_KIJ  = 9;
    localparam int LEN_NIJ  = 36;
    localparam int LEN_ONIJ = 16;
    localparam int GAP      = 10;
    localparam int PER_KIJ  = 2*COL + GAP + 3*LEN_NIJ + COL + ROW + LEN_ONIJ;
    localparam int TOTAL    = LEN_KIJ*PER_KIJ + LEN_ONIJ*(LEN_KIJ+3) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode_in;
    logic [33:0] inst;
    logic        core_clr;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [33:0] w;
        logic        clr;
        logic        ov;
        logic [3:0]  idx;
        logic        bsy;
        logic        dn;
    } exp_t;

    exp_t q[$];
    int   a_pmem_q[$];
    int   ov_idx[$];
    int   act_cnt, ofifo_cnt, ov_cnt, done_cnt;

    always #5 clk = ~clk;

    core_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode_in   (mode_in),
        .inst      (inst),
        .core_clr  (core_clr),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] obs_now();
        return {inst, core_clr, out_valid, out_valid ? out_idx : 4'd0, busy, done};
    endfunction

    function automatic logic [33:0] mk(input bit m, input bit acc, input bit cenp,
                                       input int ap, input bit cenx, input int ax,
                                       input logic [6:0] strb);
        logic [33:0] w;
        logic [10:0] a;
        a       = 11'(ax);
        w       = '0;
        w[33]   = acc;
        w[32]   = cenp;
        w[31]   = 1'b1;
        w[30:20]= 11'(ap);
        w[19]   = cenx;
        w[18]   = 1'b1;
        w[17:9] = a[10:2];
        w[8]    = m;
        w[7]    = a[0];
        w[6:0]  = strb;
        return w;
    endfunction

    function automatic exp_t idle_e();
        return '{w: mk(0, 0, 1, 0, 1, 0, 7'b0), clr: 0, ov: 0, idx: 0, bsy: 0, dn: 0};
    endfunction

    task automatic push(input logic [33:0] w, input bit clr, input bit ov,
                        input int idx, input bit bsy, input bit dn);
        q.push_back('{w: w, clr: clr, ov: ov, idx: 4'(idx), bsy: bsy, dn: dn});
    endtask

    task automatic build(input bit m);
        q.delete();
        for (int k = 0; k < LEN_KIJ; k++) begin
            for (int t = 0; t < COL; t++)
                push(mk(m, 0, 1, 0, 0, 'h400 + k*COL + t, 7'b0000100), 0, 0, 0, 1, 0);
            for (int t = 0; t < COL; t++)
                push(mk(m, 0, 1, 0, 1, 0, 7'b0001001), 0, 0, 0, 1, 0);
            for (int t = 0; t < GAP; t++)
                push(mk(m, 0, 1, 0, 1, 0, 7'b0), 0, 0, 0, 1, 0);
            for (int t = 0; t < LEN_NIJ; t++)
                push(mk(m, 0, 1, 0, 0, t, 7'b0000100), 0, 0, 0, 1, 0);
            for (int t = 0; t < LEN_NIJ; t++)
                push(mk(m, 0, 1, 0, 1, 0, 7'b0101000), 0, 0, 0, 1, 0);
            for (int t = 0; t < LEN_NIJ + COL + ROW; t++)
                push(mk(m, 0, 1, 0, 1, 0, 7'b0010010), 0, 0, 0, 1, 0);
            for (int t = 0; t < LEN_ONIJ; t++)
                push(mk(m, 0, 1, 0, 1, 0, 7'b1000000), 0, 0, 0, 1, 0);
        end
        for (int o = 0; o < LEN_ONIJ; o++) begin
            push(mk(m, 0, 1, 0, 1, 0, 7'b0), 1, 0, 0, 1, 0);
            for (int j = 0; j <= LEN_KIJ; j++) begin
                if (j < LEN_KIJ)
                    push(mk(m, j >= 1, 0, j*LEN_ONIJ + o, 1, 0, 7'b0), 0, 0, 0, 1, 0);
                else
                    push(mk(m, 1, 1, 0, 1, 0, 7'b0), 0, 0, 0, 1, 0);
            end
            push(mk(m, 0, 1, 0, 1, 0, 7'b0), 0, 1, o, 1, 0);
        end
        push(mk(m, 0, 1, 0, 1, 0, 7'b0), 0, 0, 0, 0, 1);
    endtask

    task automatic kick(input bit m);
        @(negedge clk);
        start   = 1'b1;
        mode_in = m;
        @(negedge clk);
        start   = 1'b0;
        mode_in = 1'($urandom_range(0, 1));
        chk("start_gap", 64'(obs_now()), 64'(idle_e()));
    endtask

    task automatic run_tile(input bit m, input string nm);
        build(m);
        act_cnt = 0; ofifo_cnt = 0; ov_cnt = 0; done_cnt = 0;
        a_pmem_q.delete();
        ov_idx.delete();
        kick(m);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            chk($sformatf("%s_cyc%0d", nm, i), 64'(obs_now()), 64'(q[i]));
            if (busy || done) act_cnt++;
            if (inst[6]) ofifo_cnt++;
            if (done) done_cnt++;
            if (!inst[32]) a_pmem_q.push_back(int'(inst[30:20]));
            if (out_valid) begin
                ov_cnt++;
                ov_idx.push_back(int'(out_idx));
            end
            if (i < q.size() - 1) begin
                start   = ($urandom_range(0, 15) == 0);
                mode_in = 1'($urandom_range(0, 1));
            end else begin
                start   = 1'b0;
            end
        end
        @(negedge clk);
        chk({nm, "_after"}, 64'(obs_now()), 64'(idle_e()));
        chk({nm, "_cycles"}, 64'(act_cnt), 64'(TOTAL));
        chk({nm, "_ofifo"}, 64'(ofifo_cnt), 64'(LEN_KIJ * LEN_ONIJ));
        chk({nm, "_nvalid"}, 64'(ov_cnt), 64'(LEN_ONIJ));
        chk({nm, "_ndone"}, 64'(done_cnt), 64'(1));
        chk({nm, "_npmem"}, 64'(a_pmem_q.size()), 64'(LEN_ONIJ * LEN_KIJ));
        for (int i = 0; i < LEN_ONIJ; i++)
            if (i < ov_idx.size())
                chk($sformatf("%s_idx%0d", nm, i), 64'(ov_idx[i]), 64'(i));
        for (int j = 0; j < LEN_KIJ; j++)
            if (5*LEN_KIJ + j < a_pmem_q.size())
                chk($sformatf("%s_apmem_o5_j%0d", nm, j),
                    64'(a_pmem_q[5*LEN_KIJ + j]), 64'(5 + j*LEN_ONIJ));
    endtask

    task automatic run_abort(input bit m, input int at);
        build(m);
        kick(m);
        for (int i = 0; i < at; i++) begin
            @(negedge clk);
            chk($sformatf("abort_cyc%0d", i), 64'(obs_now()), 64'(q[i]));
            mode_in = 1'($urandom_range(0, 1));
        end
        #2 reset = 1'b1;
        #1 chk("abort_async", 64'(obs_now()), 64'(idle_e()));
        @(negedge clk);
        chk("abort_held", 64'(obs_now()), 64'(idle_e()));
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("abort_idle%0d", i), 64'(obs_now()), 64'(idle_e()));
        end
    endtask

    initial begin
        int kk;
        int at;
        reset   = 1'b0;
        start   = 1'b0;
        mode_in = 1'b0;
        #1 reset = 1'b1;
        #2 chk("reset_async", 64'(obs_now()), 64'(idle_e()));
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", 64'(obs_now()), 64'(idle_e()));
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start", 64'(obs_now()), 64'(idle_e()));

        run_tile(1'b1, "run_m1");
        run_tile(1'b0, "run_m0");

        kk = int'($urandom_range(0, LEN_KIJ - 1));
        at = kk*PER_KIJ + 2*COL + GAP + int'($urandom_range(1, LEN_NIJ - 1));
        run_abort(1'($urandom_range(0, 1)), at);

        run_tile(1'($urandom_range(0, 1)), "run_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
